// File: rtl/tsip_timing_packet_tx.sv
`default_nettype none
// ============================================================================
// Module      : tsip_timing_packet_tx
// Description : Serialises a TSIP 8F-AB primary timing packet, DLE-stuffed,
//               onto a one-byte-at-a-time uart_tx handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tsip_timing_packet_tx #(
  parameter logic [7:0] P_DLE     = 8'h10,
  parameter logic [7:0] P_ETX     = 8'h03,
  parameter logic [7:0] P_ID      = 8'h8F,
  parameter logic [7:0] P_SUBCODE = 8'hAB
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_send,
  input  logic [31:0] i_tow,
  input  logic [15:0] i_week,
  input  logic [15:0] i_utc_offset,
  input  logic [7:0]  i_timing_flag,
  input  logic [7:0]  i_seconds,
  input  logic [7:0]  i_minutes,
  input  logic [7:0]  i_hours,
  input  logic [7:0]  i_day,
  input  logic [7:0]  i_month,
  input  logic [15:0] i_year,
  output logic        o_tx_dv,
  output logic [7:0]  o_tx_byte,
  input  logic        i_tx_done,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_send_dropped
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_ISSUE       = 3'd1;
  localparam logic [2:0] S_WAIT        = 3'd2;
  localparam logic [2:0] S_STUFF_ISSUE = 3'd3;
  localparam logic [2:0] S_STUFF_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE        = 3'd5;

  localparam logic [4:0] C_LAST_IDX  = 5'd20;
  localparam logic [4:0] C_LAST_BODY = 5'd18;

  logic [2:0]  r_state;
  logic [4:0]  r_idx;
  logic [31:0] r_tow;
  logic [15:0] r_week;
  logic [15:0] r_utc;
  logic [7:0]  r_flag;
  logic [7:0]  r_sec;
  logic [7:0]  r_min;
  logic [7:0]  r_hr;
  logic [7:0]  r_day;
  logic [7:0]  r_mon;
  logic [15:0] r_year;
  logic        r_tx_dv;
  logic [7:0]  r_tx_byte;
  logic        r_busy;
  logic        r_done;
  logic        r_drop;

  logic [4:0]  w_next_idx;
  logic [7:0]  w_next_byte;
  logic        w_needs_stuff;

  assign w_next_idx = r_idx + 5'd1;

  // Only the ID and body may be stuffed; the opening and closing DLEs never are.
  assign w_needs_stuff = (r_idx != 5'd0) && (r_idx <= C_LAST_BODY) && (r_tx_byte == P_DLE);

  always_comb begin
    w_next_byte = 8'h00;
    case (w_next_idx)
      5'd0:    w_next_byte = P_DLE;
      5'd1:    w_next_byte = P_ID;
      5'd2:    w_next_byte = P_SUBCODE;
      5'd3:    w_next_byte = r_tow[31:24];
      5'd4:    w_next_byte = r_tow[23:16];
      5'd5:    w_next_byte = r_tow[15:8];
      5'd6:    w_next_byte = r_tow[7:0];
      5'd7:    w_next_byte = r_week[15:8];
      5'd8:    w_next_byte = r_week[7:0];
      5'd9:    w_next_byte = r_utc[15:8];
      5'd10:   w_next_byte = r_utc[7:0];
      5'd11:   w_next_byte = r_flag;
      5'd12:   w_next_byte = r_sec;
      5'd13:   w_next_byte = r_min;
      5'd14:   w_next_byte = r_hr;
      5'd15:   w_next_byte = r_day;
      5'd16:   w_next_byte = r_mon;
      5'd17:   w_next_byte = r_year[15:8];
      5'd18:   w_next_byte = r_year[7:0];
      5'd19:   w_next_byte = P_DLE;
      5'd20:   w_next_byte = P_ETX;
      default: w_next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_idx     <= 5'd0;
      r_tow     <= 32'h0;
      r_week    <= 16'h0;
      r_utc     <= 16'h0;
      r_flag    <= 8'h0;
      r_sec     <= 8'h0;
      r_min     <= 8'h0;
      r_hr      <= 8'h0;
      r_day     <= 8'h0;
      r_mon     <= 8'h0;
      r_year    <= 16'h0;
      r_tx_dv   <= 1'b0;
      r_tx_byte <= 8'h00;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_tx_dv <= 1'b0;
      r_done  <= 1'b0;
      r_drop  <= i_send & r_busy;
      case (r_state)
        S_IDLE: begin
          if (i_send) begin
            r_tow     <= i_tow;
            r_week    <= i_week;
            r_utc     <= i_utc_offset;
            r_flag    <= i_timing_flag;
            r_sec     <= i_seconds;
            r_min     <= i_minutes;
            r_hr      <= i_hours;
            r_day     <= i_day;
            r_mon     <= i_month;
            r_year    <= i_year;
            r_idx     <= 5'd0;
            r_tx_byte <= P_DLE;
            r_tx_dv   <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE:       r_state <= S_WAIT;
        S_STUFF_ISSUE: r_state <= S_STUFF_WAIT;
        S_WAIT, S_STUFF_WAIT: begin
          if (i_tx_done) begin
            if ((r_state == S_WAIT) && w_needs_stuff) begin
              r_tx_dv <= 1'b1;
              r_state <= S_STUFF_ISSUE;
            end else if (r_idx == C_LAST_IDX) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx     <= w_next_idx;
              r_tx_byte <= w_next_byte;
              r_tx_dv   <= 1'b1;
              r_state   <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tx_dv        = r_tx_dv;
  assign o_tx_byte      = r_tx_byte;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_send_dropped = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_tsip_timing_packet_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_tsip_timing_packet_tx
// Description : Self-checking bench for tsip_timing_packet_tx with a uart_tx
//               responder and a framing/stuffing reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tsip_timing_packet_tx;

  typedef struct {
    logic [31:0] tow;
    logic [15:0] week;
    logic [15:0] off;
    logic [7:0]  flag;
    logic [7:0]  sec;
    logic [7:0]  min;
    logic [7:0]  hr;
    logic [7:0]  day;
    logic [7:0]  mon;
    logic [15:0] year;
    int          exp_len;
    int          delay;
  } vec_t;

  logic        clk;
  logic        i_rst;
  logic        i_send;
  logic [31:0] f_tow;
  logic [15:0] f_week;
  logic [15:0] f_off;
  logic [7:0]  f_flag;
  logic [7:0]  f_sec;
  logic [7:0]  f_min;
  logic [7:0]  f_hr;
  logic [7:0]  f_day;
  logic [7:0]  f_mon;
  logic [15:0] f_year;
  logic        o_tx_dv;
  logic [7:0]  o_tx_byte;
  logic        i_tx_done;
  logic        o_busy;
  logic        o_done;
  logic        o_send_dropped;

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int drop_cnt = 0;
  int resp_delay = 10;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  vec_t vecs[$];
  logic [7:0] t1_lit [0:20];

  tsip_timing_packet_tx dut (
    .i_clk(clk), .i_rst(i_rst), .i_send(i_send),
    .i_tow(f_tow), .i_week(f_week), .i_utc_offset(f_off), .i_timing_flag(f_flag),
    .i_seconds(f_sec), .i_minutes(f_min), .i_hours(f_hr), .i_day(f_day),
    .i_month(f_mon), .i_year(f_year),
    .o_tx_dv(o_tx_dv), .o_tx_byte(o_tx_byte), .i_tx_done(i_tx_done),
    .o_busy(o_busy), .o_done(o_done), .o_send_dropped(o_send_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: framed 8F-AB packet, every 0x10 from ID through the body doubled.
  task automatic build_exp(input vec_t v);
    logic [135:0] body;
    logic [7:0]   b;
    body = {8'hAB, v.tow, v.week, v.off, v.flag, v.sec, v.min, v.hr, v.day, v.mon, v.year};
    exp_q.delete();
    exp_q.push_back(8'h10);
    for (int i = -1; i < 17; i++) begin
      b = (i < 0) ? 8'h8F : body[135 - 8*i -: 8];
      exp_q.push_back(b);
      if (b == 8'h10) exp_q.push_back(b);
    end
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h03);
  endtask

  task automatic set_fields(input vec_t v);
    f_tow = v.tow; f_week = v.week; f_off = v.off; f_flag = v.flag;
    f_sec = v.sec; f_min = v.min; f_hr = v.hr; f_day = v.day;
    f_mon = v.mon; f_year = v.year;
  endtask

  task automatic scramble_fields();
    f_tow = $urandom; f_week = 16'($urandom); f_off = 16'($urandom);
    f_flag = 8'($urandom); f_sec = 8'($urandom); f_min = 8'($urandom);
    f_hr = 8'($urandom); f_day = 8'($urandom); f_mon = 8'($urandom);
    f_year = 16'($urandom);
  endtask

  function automatic logic [7:0] rb8();
    return ($urandom_range(0, 3) == 0) ? 8'h10 : 8'($urandom);
  endfunction

  task automatic start_send();
    @(negedge clk);
    i_send = 1'b1;
    @(negedge clk);
    i_send = 1'b0;
    chk("first_dv", o_tx_dv, 1'b1);
    chk("first_byte", o_tx_byte, 8'h10);
  endtask

  task automatic wait_done(input bit scramble);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      if (scramble) scramble_fields();
      n++;
    end while (!o_done && n < 4000);
    chk("done_seen", o_done, 1'b1);
  endtask

  task automatic cmp_pkt(input string name);
    chk({name, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk({name, "_byte"}, got[i], exp_q[i]);
  endtask

  task automatic apply(input vec_t v, input bit scramble);
    set_fields(v);
    resp_delay = v.delay;
    build_exp(v);
    got.delete();
    done_cnt = 0;
    start_send();
    wait_done(scramble);
    @(negedge clk);
    chk("busy_after_done", o_busy, 1'b0);
    chk("done_count", done_cnt, 1);
    cmp_pkt("pkt");
    if (v.exp_len > 0) chk("wire_len", got.size(), v.exp_len);
  endtask

  // uart_tx stand-in: one done pulse resp_delay cycles after each strobe.
  initial begin
    int cnt;
    bit outstanding;
    bit pend_gap;
    i_tx_done = 1'b0;
    cnt = 0; outstanding = 0; pend_gap = 0;
    forever begin
      @(negedge clk);
      i_tx_done = 1'b0;
      if (pend_gap && o_busy && !o_done) chk("dv_after_txdone", o_tx_dv, 1'b1);
      pend_gap = 0;
      if (o_done) done_cnt++;
      if (o_send_dropped) drop_cnt++;
      if (o_tx_dv === 1'b1) begin
        chk("single_outstanding", outstanding, 1'b0);
        got.push_back(o_tx_byte);
        outstanding = 1;
        cnt = resp_delay;
      end else if (outstanding) begin
        cnt--;
        if (cnt <= 0) begin
          i_tx_done = 1'b1;
          outstanding = 0;
          pend_gap = 1;
        end
      end
    end
  end

  initial begin
    vec_t v1, v;
    int dvs;
    i_rst = 1'b1;
    i_send = 1'b0;
    t1_lit = '{8'h10, 8'h8F, 8'hAB, 8'h00, 8'h01, 8'hE2, 8'h40, 8'h08, 8'h97, 8'h00, 8'h12,
               8'h03, 8'h38, 8'h22, 8'h0C, 8'h0F, 8'h03, 8'h07, 8'hE8, 8'h10, 8'h03};
    v1.tow = 32'h0001E240; v1.week = 16'h0897; v1.off = 16'h0012; v1.flag = 8'h03;
    v1.sec = 8'd56; v1.min = 8'd34; v1.hr = 8'd12; v1.day = 8'd15; v1.mon = 8'd3;
    v1.year = 16'd2024; v1.exp_len = 21; v1.delay = 10;
    set_fields(v1);

    repeat (3) @(negedge clk);
    chk("rst_dv", o_tx_dv, 1'b0);
    chk("rst_byte", o_tx_byte, 8'h00);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_drop", o_send_dropped, 1'b0);
    i_rst = 1'b0;
    repeat (2) @(negedge clk);

    vecs.push_back(v1);
    v = v1; v.sec = 8'h10; v.exp_len = 22; v.delay = 3; vecs.push_back(v);
    v = v1; v.year = 16'h1010; v.tow = 32'h10101010; v.exp_len = 27; v.delay = 1; vecs.push_back(v);
    for (int i = 0; i < 8; i++) begin
      v.tow = {rb8(), rb8(), rb8(), rb8()}; v.week = {rb8(), rb8()}; v.off = {rb8(), rb8()};
      v.flag = rb8(); v.sec = rb8(); v.min = rb8(); v.hr = rb8(); v.day = rb8();
      v.mon = rb8(); v.year = {rb8(), rb8()}; v.exp_len = 0; v.delay = $urandom_range(1, 8);
      vecs.push_back(v);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], 1'b1);
      if (i == 0)
        for (int k = 0; k < 21 && k < got.size(); k++) chk("t1_literal", got[k], t1_lit[k]);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Second request during byte 5 is dropped; packet in flight unchanged.
    set_fields(v1); resp_delay = 10; build_exp(v1); got.delete(); done_cnt = 0; drop_cnt = 0;
    start_send();
    dvs = 1;
    for (int n = 0; n < 500 && dvs < 5; n++) begin
      @(negedge clk);
      if (o_tx_dv) dvs++;
    end
    i_send = 1'b1;
    @(negedge clk);
    i_send = 1'b0;
    chk("drop_pulse", o_send_dropped, 1'b1);
    wait_done(1'b0);
    repeat (30) @(negedge clk);
    chk("drop_count", drop_cnt, 1);
    chk("drop_done_count", done_cnt, 1);
    cmp_pkt("drop_pkt");

    // Reset two cycles after the 7th strobe aborts the packet.
    set_fields(v1); resp_delay = 10; got.delete();
    start_send();
    dvs = 1;
    for (int n = 0; n < 500 && dvs < 7; n++) begin
      @(negedge clk);
      if (o_tx_dv) dvs++;
    end
    repeat (2) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", o_busy, 1'b0);
    chk("midrst_dv", o_tx_dv, 1'b0);
    chk("midrst_done", o_done, 1'b0);
    i_rst = 1'b0;
    repeat (20) @(negedge clk);
    apply(v1, 1'b0);

    // Held request: back-to-back packets.
    set_fields(v1); resp_delay = 2; build_exp(v1); got.delete(); done_cnt = 0;
    @(negedge clk);
    i_send = 1'b1;
    for (int p = 0; p < 3; p++) begin
      wait_done(1'b0);
      @(negedge clk);
      if (p == 2) i_send = 1'b0;
      chk("b2b_idle_busy", o_busy, 1'b0);
      chk("b2b_idle_dv", o_tx_dv, 1'b0);
      if (p < 2) begin
        @(negedge clk);
        chk("b2b_restart_dv", o_tx_dv, 1'b1);
        chk("b2b_restart_byte", o_tx_byte, 8'h10);
      end
    end
    repeat (30) @(negedge clk);
    chk("b2b_done_count", done_cnt, 3);
    chk("b2b_len", got.size(), 3 * exp_q.size());
    for (int i = 0; i < got.size() && i < 3 * exp_q.size(); i++)
      chk("b2b_byte", got[i], exp_q[i % exp_q.size()]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
